// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST corner detector: FSM states and
// the 16-point Bresenham circle used to fetch neighbours.
package fast_pkg;

    localparam int unsigned CIRCLE_N = 16;
    localparam int unsigned FETCH_N  = CIRCLE_N + 1;
    localparam int unsigned KW       = $clog2(FETCH_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NEXT,
        S_WBORD,
        S_FETCH,
        S_CAP,
        S_WRITE,
        S_FIN
    } state_e;

    // Circle offsets, index 0 at the top, proceeding clockwise.
    localparam int CIRCLE_DX [CIRCLE_N] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CIRCLE_DY [CIRCLE_N] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    // Fetch slot 0 is the centre pixel; slots 1..16 walk the circle.
    function automatic int fetch_dx(input logic [KW-1:0] k);
        return (k == '0) ? 0 : CIRCLE_DX[4'(k - KW'(1))];
    endfunction

    function automatic int fetch_dy(input logic [KW-1:0] k);
        return (k == '0) ? 0 : CIRCLE_DY[4'(k - KW'(1))];
    endfunction

endpackage

// File: rtl/fast_arc_detect.sv
// Circular contiguous-run detector: flags a corner when either mask holds a
// run of at least ARC_MIN set bits, with bit 15 adjacent to bit 0.
module fast_arc_detect
    import fast_pkg::*;
#(
    parameter int unsigned ARC_MIN = 9
) (
    input  logic [CIRCLE_N-1:0] bright_mask,
    input  logic [CIRCLE_N-1:0] dark_mask,
    output logic                is_corner
);

    // Doubling the mask turns any wrapping arc into a plain linear run.
    function automatic logic has_run(input logic [CIRCLE_N-1:0] m);
        logic [2*CIRCLE_N-1:0] dbl;
        int unsigned           run;
        logic                  found;
        dbl   = {m, m};
        run   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2 * CIRCLE_N; i++) begin
            run = dbl[i] ? run + 1 : 0;
            if (run >= ARC_MIN) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    always_comb begin
        is_corner = has_run(bright_mask) || has_run(dark_mask);
    end

endmodule

// File: rtl/orb_fast_detect.sv
// FAST corner detector: raster-scans the smoothed image, fetches centre plus
// 16 circle pixels per interior pixel, and writes a 1-bit corner map.
module orb_fast_detect
    import fast_pkg::*;
#(
    parameter int unsigned X_MAX       = 400,
    parameter int unsigned Y_MAX       = 400,
    parameter int unsigned PIXEL_DEPTH = 8,
    parameter int unsigned ARC_MIN     = 9
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(X_MAX):0]                 img_w,
    input  logic [$clog2(Y_MAX):0]                 img_h,
    input  logic [PIXEL_DEPTH-1:0]                 threshold,
    output logic [$clog2(X_MAX):0]                 x_addr_conv_fast,
    output logic [$clog2(Y_MAX):0]                 y_addr_conv_fast,
    output logic                                   ren_conv_fast,
    input  logic [PIXEL_DEPTH-1:0]                 rdat_conv_fast,
    output logic [$clog2(X_MAX):0]                 x_addr_fast,
    output logic [$clog2(Y_MAX):0]                 y_addr_fast,
    output logic                                   wen_fast,
    output logic                                   wdat_fast,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(X_MAX*Y_MAX+1)-1:0]       corner_count
);

    localparam int unsigned XW  = $clog2(X_MAX) + 1;
    localparam int unsigned YW  = $clog2(Y_MAX) + 1;
    localparam int unsigned XW1 = XW + 1;
    localparam int unsigned YW1 = YW + 1;
    localparam int unsigned CW  = $clog2(X_MAX * Y_MAX + 1);
    localparam int unsigned PW  = PIXEL_DEPTH;
    localparam int unsigned PW1 = PW + 1;

    state_e             state_q, state_d;
    logic [XW-1:0]      w_q, w_d, x_q, x_d, xa_q, xa_d;
    logic [YW-1:0]      h_q, h_d, y_q, y_d, ya_q, ya_d;
    logic [PW-1:0]      t_q, t_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ren_q, ren_d, wen_q, wen_d, wdat_q, wdat_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [PW-1:0]      smp_q [FETCH_N];
    logic [PW-1:0]      smp_d [FETCH_N];

    logic               border_c, last_c, shift_c, is_corner_c;
    logic [CIRCLE_N-1:0] bright_c, dark_c;

    assign border_c = (x_q < XW'(3)) || (y_q < YW'(3))
                   || (XW1'(x_q) + XW1'(4) > XW1'(w_q))
                   || (YW1'(y_q) + YW1'(4) > YW1'(h_q));
    assign last_c   = (x_q == w_q - XW'(1)) && (y_q == h_q - YW'(1));
    assign shift_c  = ((state_q == S_FETCH) && (k_q != '0)) || (state_q == S_CAP);

    // Sample k lands one cycle after its read; slot 0 ends up as the centre.
    always_comb begin
        smp_d = smp_q;
        if (shift_c) begin
            for (int unsigned i = 0; i < FETCH_N - 1; i++) begin
                smp_d[i] = smp_q[i+1];
            end
            smp_d[FETCH_N-1] = rdat_conv_fast;
        end
    end

    // Widened compares so c+t and p+t never wrap.
    always_comb begin
        bright_c = '0;
        dark_c   = '0;
        for (int unsigned i = 0; i < CIRCLE_N; i++) begin
            bright_c[i] = PW1'(smp_d[i+1]) > (PW1'(smp_d[0]) + PW1'(t_q));
            dark_c[i]   = (PW1'(smp_d[i+1]) + PW1'(t_q)) < PW1'(smp_d[0]);
        end
    end

    fast_arc_detect #(
        .ARC_MIN (ARC_MIN)
    ) u_arc (
        .bright_mask (bright_c),
        .dark_mask   (dark_c),
        .is_corner   (is_corner_c)
    );

    // Next-state logic; port values are decided one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        t_d     = t_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        wdat_d  = 1'b0;
        xa_d    = '0;
        ya_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    w_d     = img_w;
                    h_d     = img_h;
                    t_d     = threshold;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
                state_d = ((w_q == '0) || (h_q == '0)) ? S_FIN : S_NEXT;
            end
            S_NEXT: begin
                xa_d = x_q;
                ya_d = y_q;
                if (border_c) begin
                    state_d = S_WBORD;
                    wen_d   = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    k_d     = '0;
                    ren_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (k_q == KW'(FETCH_N - 1)) begin
                    state_d = S_CAP;
                end else begin
                    k_d   = k_q + KW'(1);
                    ren_d = 1'b1;
                    xa_d  = XW'(int'(x_q) + fetch_dx(k_d));
                    ya_d  = YW'(int'(y_q) + fetch_dy(k_d));
                end
            end
            S_CAP: begin
                state_d = S_WRITE;
                wen_d   = 1'b1;
                wdat_d  = is_corner_c;
                xa_d    = x_q;
                ya_d    = y_q;
            end
            S_WBORD, S_WRITE: begin
                if (state_q == S_WRITE) begin
                    cnt_d = cnt_q + CW'(wdat_q);
                end
                if (last_c) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_NEXT;
                    if (x_q == w_q - XW'(1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            t_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            wdat_q  <= 1'b0;
            xa_q    <= '0;
            ya_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            smp_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            t_q     <= t_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            wdat_q  <= wdat_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            smp_q   <= smp_d;
        end
    end

    assign x_addr_conv_fast = ren_q ? xa_q : '0;
    assign y_addr_conv_fast = ren_q ? ya_q : '0;
    assign ren_conv_fast    = ren_q;
    assign x_addr_fast      = wen_q ? xa_q : '0;
    assign y_addr_fast      = wen_q ? ya_q : '0;
    assign wen_fast         = wen_q;
    assign wdat_fast        = wdat_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign corner_count     = cnt_q;

endmodule
